autoc_delay_ctrl: RTL and testbench
===================================

# autoc_delay_ctrl

Runtime-programmable delay-line controller for the autocorrelation datapath. It sequences a dual-port RAM as a circular buffer, and delays a strobe-qualified sample stream by a delay that software can change at any time. After every delay change it tracks priming, and reports through `primed` when the output carries real delayed data. It sits between the sample source and the autocorrelation multiply/accumulate stage, and replaces the fixed-length register delay.

## Interface
Parameters:
- `WIDTH`, 16, sample width in bits.
- `AWIDTH`, 6, RAM address width; DEPTH = 2^AWIDTH; maximum delay DEPTH-1.
- `INIT_DELAY`, 8, delay loaded at reset; must be ≤ DEPTH-1.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `set_stb` in 1: one-cycle strobe that loads `set_delay`.
- `set_delay` in AWIDTH: requested delay in samples.
- `in_stb` in 1: input sample valid.
- `din` in WIDTH: input sample.
- `out_stb` out 1: output sample valid.
- `dout` out WIDTH: delayed sample.
- `primed` out 1: high when `dout` is real data delayed by the current delay.
- `cur_delay` out AWIDTH: delay currently in effect.

## Operation
- State machine has two states: PRIME and RUN.
  - Reset enters PRIME with delay = INIT_DELAY.
- Write pointer `wr_ptr` (AWIDTH bits):
  - Increments mod DEPTH on each `in_stb`.
  - `din` is written at `wr_ptr`.
- Read address = (`wr_ptr` − delay) mod DEPTH, computed in AWIDTH-bit unsigned arithmetic with natural wrap.
  - The read uses the same-cycle address, before the write.
- Prime counter `pcnt` (AWIDTH+1 bits):
  - Cleared on entry to PRIME.
  - Increments on each `in_stb` while in PRIME.
  - PRIME→RUN on the `in_stb` cycle where `pcnt == delay`.
- Output rule: the k-th strobe after entering PRIME (k = 0 first) outputs `din` of strobe k−delay.
  - Valid for k ≥ delay. For k < delay, output follows the Configuration section.
- Delay 0 means registered pass-through: RUN is entered on the first `in_stb` after the set, and `dout` = `din`.
- `set_stb` in any state:
  - Latches `set_delay` into `cur_delay`, clears `pcnt`, enters PRIME and drops `primed` next cycle.
  - `wr_ptr` is not reset.
- `set_stb` and `in_stb` in the same cycle: the setting takes effect first. The sample is written and counts as k = 0 of the new priming.
- `set_stb` with the same value as `cur_delay` still re-primes.
- No backpressure: `in_stb` may be asserted every cycle.

## Timing
- Latency is 1 clk: `out_stb` is `in_stb` registered, and `dout` is the registered RAM read.
- `primed` is registered and aligned with `out_stb`: it rises in the cycle that outputs k = delay.
- `primed` falls in the cycle after `set_stb`.
- `cur_delay` updates in the cycle after `set_stb`.
- Reset values:
  - `out_stb` = 0, `dout` = 0, `primed` = 0.
  - `cur_delay` = INIT_DELAY, `wr_ptr` = 0, `pcnt` = 0, state PRIME.
- RAM contents are not reset.
- Reset mid-stream: all controller state returns to reset values in the next cycle, and any in-flight output is dropped.

## Configuration
- Macro: `AUTOC_DELAY_CTRL_ZERO_FILL_EN`.
- Defined: while `primed` = 0 and `out_stb` = 1, `dout` is forced to 0. This gives the zero-history behaviour the autocorrelator expects.
- Undefined: `dout` during priming is the raw RAM content (stale data), which saves the output mux. Downstream must gate on `primed`.
- All other behaviour is identical in both builds.

## Structure
- Package `autoc_delay_pkg` holds:
  - state enum `delay_state_t` {PRIME, RUN};
  - default constants for WIDTH, AWIDTH and INIT_DELAY.
- Sub-module `autoc_delay_ram`:
  - simple dual-port RAM, one write port and one read port, registered read data;
  - read-before-write on an address collision;
  - parameters WIDTH and AWIDTH.
- Pointer arithmetic, the state machine and the output register live in `autoc_delay_ctrl`.

## Test plan
- Reset, then `in_stb` every cycle with `din` = 1,2,3,… and INIT_DELAY = 8:
  - strobes 0–7 give `dout` = 0 with `primed` = 0 (ZERO_FILL build);
  - strobe 8 gives `dout` = 1 with `primed` = 1;
  - thereafter `dout` = `din` − 8.
- Delay 0, then `din` = 0x00AA: `out_stb` is seen one clk later with `dout` = 0x00AA and `primed` = 1.
- Delay = DEPTH−1 (63) with more than 200 continuous strobes across `wr_ptr` wrap: `dout` = `din` − 63 throughout, with no glitch at the wrap.
- In RUN at delay 8, `set_stb` with `set_delay` = 3 together with `in_stb`:
  - `primed` falls next cycle;
  - three strobes are output as zero fill;
  - the fourth outputs the `din` from the set cycle, with `primed` = 1.
- Bursty `in_stb` (random gaps, 50% duty) at delay 5: the output at strobe k equals `din` at strobe k−5, and idle cycles have no effect.
- Assert `rst` mid-stream in RUN: the next cycle has `out_stb` = 0, `primed` = 0 and `cur_delay` = 8, and priming restarts from k = 0.

Source files
------------

// File: rtl/autoc_delay_pkg.sv
// Shared types and default constants for the autocorrelation delay line.
package autoc_delay_pkg;

    // Two-state priming FSM: PRIME until the buffer holds `delay` samples, then RUN.
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } delay_state_t;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_AWIDTH     = 6;
    localparam int DEF_INIT_DELAY = 8;

endpackage : autoc_delay_pkg

// File: rtl/autoc_delay_ram.sv
// Simple dual-port RAM: one write port, one read port with registered data.
// A read and a write to the same address in one cycle return the old contents.
module autoc_delay_ram #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**AWIDTH];

    // Write port.
    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; sees pre-write contents on an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : autoc_delay_ram

// File: rtl/autoc_delay_ctrl.sv
// Runtime-programmable delay-line controller: circular-buffer pointers,
// priming FSM and output stage around autoc_delay_ram.
// Optional build macro: AUTOC_DELAY_CTRL_ZERO_FILL_EN forces dout to zero
// for output strobes produced while still priming.
module autoc_delay_ctrl
    import autoc_delay_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int AWIDTH     = DEF_AWIDTH,
    parameter int INIT_DELAY = DEF_INIT_DELAY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_stb,
    input  logic [AWIDTH-1:0] set_delay,
    input  logic              in_stb,
    input  logic [WIDTH-1:0]  din,
    output logic              out_stb,
    output logic [WIDTH-1:0]  dout,
    output logic              primed,
    output logic [AWIDTH-1:0] cur_delay
);

    delay_state_t      state;
    delay_state_t      eff_state;
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] eff_delay;
    logic [AWIDTH-1:0] rd_addr;
    logic [AWIDTH:0]   pcnt;
    logic [AWIDTH:0]   eff_pcnt;
    logic              prime_done;
    logic              byp_q;
    logic [WIDTH-1:0]  byp_data;
    logic [WIDTH-1:0]  ram_rdata;
    logic [WIDTH-1:0]  dout_raw;

    // A same-cycle set_stb takes effect before the sample: resolve the view this cycle acts on.
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        eff_state = state;
        eff_delay = cur_delay;
        eff_pcnt  = pcnt;
        if (set_stb) begin
            eff_state = PRIME;
            eff_delay = set_delay;
            eff_pcnt  = '0;
        end
        prime_done = in_stb && (eff_pcnt == {1'b0, eff_delay});
    end

    // Read trails the write pointer by the delay; AWIDTH-bit arithmetic wraps naturally.
    assign rd_addr = wr_ptr - eff_delay;

    autoc_delay_ram #(
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (in_stb),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (in_stb),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Pointer, delay register, priming FSM and registered strobe/primed outputs.
    // NOTE: non-blocking assignments here so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PRIME;
            cur_delay <= AWIDTH'(INIT_DELAY);
            wr_ptr    <= '0;
            pcnt      <= '0;
            primed    <= 1'b0;
            out_stb   <= 1'b0;
            byp_q     <= 1'b0;
            byp_data  <= '0;
        end else begin
            out_stb <= in_stb;
            // Delay 0 cannot come from a read-before-write RAM, so the sample bypasses it.
            byp_q   <= in_stb && (eff_delay == '0);
            if (in_stb) begin
                byp_data <= din;
                wr_ptr   <= wr_ptr + AWIDTH'(1);
            end
            if (set_stb) begin
                cur_delay <= set_delay;
            end
            case (eff_state)
                PRIME: begin
                    if (prime_done) begin
                        state  <= RUN;
                        primed <= 1'b1;
                    end else begin
                        state  <= PRIME;
                        primed <= 1'b0;
                        pcnt   <= in_stb ? eff_pcnt + (AWIDTH+1)'(1) : eff_pcnt;
                    end
                end
                RUN: begin
                    state  <= RUN;
                    primed <= 1'b1;
                end
                default: begin
                    state  <= PRIME;
                    primed <= 1'b0;
                end
            endcase
        end
    end

    assign dout_raw = byp_q ? byp_data : ram_rdata;

`ifdef AUTOC_DELAY_CTRL_ZERO_FILL_EN
    // Zero history while priming, as the autocorrelator expects.
    assign dout = (out_stb && !primed) ? '0 : dout_raw;
`else
    // Stale RAM data during priming; consumers gate on primed.
    assign dout = dout_raw;
`endif

endmodule : autoc_delay_ctrl

// File: tb/tb_autoc_delay_ctrl.sv
// Self-checking bench for autoc_delay_ctrl: reference model + scoreboard,
// a directed vector table for set/delay-0 corners, wrap, bursts and reset.
module tb_autoc_delay_ctrl;

    localparam int WIDTH  = 16;
    localparam int AWIDTH = 6;
`ifdef AUTOC_DELAY_CTRL_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              set_stb;
    logic [AWIDTH-1:0] set_delay;
    logic              in_stb;
    logic [WIDTH-1:0]  din;
    logic              out_stb;
    logic [WIDTH-1:0]  dout;
    logic              primed;
    logic [AWIDTH-1:0] cur_delay;

    autoc_delay_ctrl #(
        .WIDTH      (WIDTH),
        .AWIDTH     (AWIDTH),
        .INIT_DELAY (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .set_stb   (set_stb),
        .set_delay (set_delay),
        .in_stb    (in_stb),
        .din       (din),
        .out_stb   (out_stb),
        .dout      (dout),
        .primed    (primed),
        .cur_delay (cur_delay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             primed;
    } sb_entry_t;

    typedef struct {
        logic              set;
        logic [AWIDTH-1:0] sdel;
        logic              stb;
        logic [WIDTH-1:0]  din;
        logic              exp_stb;
        logic [WIDTH-1:0]  exp_dout;
        logic              exp_primed;
        logic [AWIDTH-1:0] exp_delay;
    } vec_t;

    int               n_tests = 0;
    int               n_fail  = 0;
    sb_entry_t        sb[$];
    logic [WIDTH-1:0] hist[$];
    int               m_delay;
    logic             m_primed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, update the model, then compare outputs after the edge.
    task automatic step(input logic s, input logic [AWIDTH-1:0] sd, input logic st,
                        input logic [WIDTH-1:0] d);
        sb_entry_t e;
        sb_entry_t got;
        int        k;
        @(negedge clk);
        set_stb   = s;
        set_delay = sd;
        in_stb    = st;
        din       = d;
        if (s) begin
            m_delay  = int'(sd);
            m_primed = 1'b0;
            hist.delete();
        end
        if (st) begin
            k = hist.size();
            hist.push_back(d);
            e.primed = (k >= m_delay);
            e.dout   = e.primed ? hist[k - m_delay] : '0;
            sb.push_back(e);
            m_primed = e.primed;
        end
        @(posedge clk);
        #1;
        check("out_stb", out_stb, st);
        if (out_stb) begin
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                got = sb.pop_front();
                check("sb_primed", primed, got.primed);
                if (ZF || got.primed) check("sb_dout", dout, got.dout);
            end
        end
        check("primed", primed, m_primed);
        check("cur_delay", cur_delay, m_delay);
    endtask

    task automatic do_reset(input logic stb);
        @(negedge clk);
        rst     = 1'b1;
        set_stb = 1'b0;
        in_stb  = stb;
        din     = 16'hDEAD;
        @(posedge clk);
        #1;
        check("rst_out_stb", out_stb, 0);
        check("rst_primed", primed, 0);
        check("rst_cur_delay", cur_delay, 8);
        check("rst_dout", dout, 0);
        m_delay  = 8;
        m_primed = 1'b0;
        hist.delete();
        sb.delete();
        @(negedge clk);
        rst    = 1'b0;
        in_stb = 1'b0;
    endtask

    vec_t tbl[15];

    initial begin
        rst       = 1'b1;
        set_stb   = 1'b0;
        set_delay = '0;
        in_stb    = 1'b0;
        din       = '0;
        m_delay   = 8;
        m_primed  = 1'b0;

        //          set   sdel  stb   din       exp_stb exp_dout  exp_p exp_delay
        tbl[0]  = '{1'b1, 6'd3, 1'b1, 16'h0100, 1'b1, 16'h0000, 1'b0, 6'd3};
        tbl[1]  = '{1'b0, 6'd0, 1'b1, 16'h0101, 1'b1, 16'h0000, 1'b0, 6'd3};
        tbl[2]  = '{1'b0, 6'd0, 1'b1, 16'h0102, 1'b1, 16'h0000, 1'b0, 6'd3};
        tbl[3]  = '{1'b0, 6'd0, 1'b1, 16'h0103, 1'b1, 16'h0100, 1'b1, 6'd3};
        tbl[4]  = '{1'b0, 6'd0, 1'b1, 16'h0104, 1'b1, 16'h0101, 1'b1, 6'd3};
        tbl[5]  = '{1'b0, 6'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 6'd3};
        tbl[6]  = '{1'b1, 6'd0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 6'd0};
        tbl[7]  = '{1'b0, 6'd0, 1'b1, 16'h00AA, 1'b1, 16'h00AA, 1'b1, 6'd0};
        tbl[8]  = '{1'b0, 6'd0, 1'b1, 16'h00BB, 1'b1, 16'h00BB, 1'b1, 6'd0};
        tbl[9]  = '{1'b1, 6'd0, 1'b1, 16'h0011, 1'b1, 16'h0011, 1'b1, 6'd0};
        tbl[10] = '{1'b1, 6'd2, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 6'd2};
        tbl[11] = '{1'b1, 6'd2, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 6'd2};
        tbl[12] = '{1'b0, 6'd0, 1'b1, 16'h0201, 1'b1, 16'h0000, 1'b0, 6'd2};
        tbl[13] = '{1'b0, 6'd0, 1'b1, 16'h0202, 1'b1, 16'h0000, 1'b0, 6'd2};
        tbl[14] = '{1'b0, 6'd0, 1'b1, 16'h0203, 1'b1, 16'h0201, 1'b1, 6'd2};

        // Reset state, then continuous stream 1,2,3,... at INIT_DELAY = 8.
        do_reset(1'b0);
        for (int i = 1; i <= 20; i++) step(1'b0, '0, 1'b1, WIDTH'(i));

        // Directed set / delay-0 / re-prime corners from RUN at delay 8.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].set, tbl[i].sdel, tbl[i].stb, tbl[i].din);
            check($sformatf("tbl%0d_out_stb", i), out_stb, tbl[i].exp_stb);
            check($sformatf("tbl%0d_primed", i), primed, tbl[i].exp_primed);
            check($sformatf("tbl%0d_cur_delay", i), cur_delay, tbl[i].exp_delay);
            if (tbl[i].exp_stb && (ZF || tbl[i].exp_primed))
                check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
        end

        // Maximum delay across several wr_ptr wraps.
        step(1'b1, 6'd63, 1'b0, '0);
        for (int i = 0; i < 260; i++) step(1'b0, '0, 1'b1, WIDTH'(16'h1000 + i));

        // Bursty input at delay 5.
        step(1'b1, 6'd5, 1'b0, '0);
        for (int i = 0; i < 300; i++)
            step(1'b0, '0, 1'($urandom_range(0, 1)), WIDTH'($urandom));

        // Reset mid-stream in RUN, then confirm priming restarts from k = 0.
        do_reset(1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, WIDTH'(16'h3000 + i));
        do_reset(1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, WIDTH'(16'h4000 + i));

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_autoc_delay_ctrl
